maxpool_conv12: RTL and testbench

Downstream stage of the 12x12 convolution core: takes the packed 10x10 feature map produced by `top_conv12` and reduces it by 2x2, stride-2 max pooling to a 5x5 map. Pooled pixels are emitted one per cycle on a ready/valid stream. The full result is also kept in a packed register for the next layer. Sequential, one window per accepted beat, so the 100-element map needs no wide comparator tree.

---
 rtl/conv12_pkg.sv | 15 +
 rtl/pool_max4.sv | 17 +
 rtl/maxpool_conv12.sv | 97 +++++++++
 tb/tb_maxpool_conv12.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv12_pkg.sv
// Shared constants and types for the 12x12 convolution core and its pooling stage.
package conv12_pkg;
  localparam int MAP_W     = 10;
  localparam int PIX_W     = 2;
  localparam int POOL_W    = MAP_W / 2;
  localparam int MAP_BITS  = MAP_W * MAP_W * PIX_W;
  localparam int POOL_N    = POOL_W * POOL_W;
  localparam int POOL_BITS = POOL_N * PIX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/pool_max4.sv
// Combinational unsigned maximum of four pixel values.
module pool_max4
  import conv12_pkg::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  input  logic [PIX_W-1:0] d,
  output logic [PIX_W-1:0] y
);
  logic [PIX_W-1:0] m_ab;
  logic [PIX_W-1:0] m_cd;

  assign m_ab = (a > b) ? a : b;
  assign m_cd = (c > d) ? c : d;
  assign y    = (m_ab > m_cd) ? m_ab : m_cd;
endmodule

// File: rtl/maxpool_conv12.sv
// 2x2 stride-2 max pooling of a captured 10x10 map, streamed one pooled pixel per beat.
module maxpool_conv12
  import conv12_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 map_valid,
  output logic                 map_ready,
  input  logic [MAP_BITS-1:0]  map_in,
  output logic                 px_valid,
  input  logic                 px_ready,
  output logic [PIX_W-1:0]     px_data,
  output logic [4:0]           px_idx,
  output logic [POOL_BITS-1:0] pool_out,
  output logic                 done,
  output logic [1:0]           dbg_state
);
  // Handshakes: a map is taken on a cycle where map_valid && map_ready, a pixel
  // on a cycle where px_valid && px_ready; a held-off beat keeps its data stable.
  state_t state, state_nxt;

  logic [MAP_BITS-1:0] map_buf;
  logic [4:0]          idx;
  logic [2:0]          win_r;
  logic [2:0]          win_c;
  logic [6:0]          e0;
  logic [6:0]          e1;
  logic [6:0]          e2;
  logic [6:0]          e3;
  logic [PIX_W-1:0]    win_max;
  logic                last_px;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (map_valid) state_nxt = RUN;
      RUN:     if (px_ready && last_px) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    map_ready = 1'b0;
    px_valid  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    map_ready = 1'b1;
      RUN:     px_valid  = 1'b1;
      DONE:    done      = 1'b1;
      default: map_ready = 1'b0;
    endcase
  end

  assign dbg_state = state;
  assign last_px   = (idx == 5'(POOL_N - 1));

  // Window origin (2r, 2c) flattens to 2*MAP_W*r + 2*c in the row-major buffer.
  assign win_r = 3'(idx / 5'(POOL_W));
  assign win_c = 3'(idx % 5'(POOL_W));
  assign e0    = 7'(win_r) * 7'(2 * MAP_W) + 7'(win_c) * 7'd2;
  assign e1    = e0 + 7'd1;
  assign e2    = e0 + 7'(MAP_W);
  assign e3    = e0 + 7'(MAP_W + 1);

  pool_max4 u_max (
    .a (map_buf[PIX_W*e0 +: PIX_W]),
    .b (map_buf[PIX_W*e1 +: PIX_W]),
    .c (map_buf[PIX_W*e2 +: PIX_W]),
    .d (map_buf[PIX_W*e3 +: PIX_W]),
    .y (win_max)
  );

  assign px_data = (state == RUN) ? win_max : '0;
  assign px_idx  = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_buf  <= '0;
      pool_out <= '0;
      idx      <= '0;
    end else if (state == IDLE && map_valid) begin
      map_buf  <= map_in;
      pool_out <= '0;
      idx      <= '0;
    end else if (state == RUN && px_ready) begin
      pool_out[PIX_W*idx +: PIX_W] <= px_data;
      // idx parks on the last slot instead of wrapping
      if (!last_px) idx <= idx + 5'd1;
    end
  end
endmodule

// File: tb/tb_maxpool_conv12.sv
// Randomised bench for maxpool_conv12 with a per-cycle compare against a queue-based pooling model.
module tb_maxpool_conv12;
  import conv12_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 map_valid;
  logic                 map_ready;
  logic [MAP_BITS-1:0]  map_in;
  logic                 px_valid;
  logic                 px_ready;
  logic [PIX_W-1:0]     px_data;
  logic [4:0]           px_idx;
  logic [POOL_BITS-1:0] pool_out;
  logic                 done;
  logic [1:0]           dbg_state;

  maxpool_conv12 dut (
    .clk       (clk),
    .rst       (rst),
    .map_valid (map_valid),
    .map_ready (map_ready),
    .map_in    (map_in),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_data   (px_data),
    .px_idx    (px_idx),
    .pool_out  (pool_out),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // map stimulus as a 2D array, packed row-major onto map_in
  logic [1:0] cur_map [MAP_W][MAP_W];
  always_comb begin
    map_in = '0;
    for (int r = 0; r < MAP_W; r++)
      for (int c = 0; c < MAP_W; c++)
        map_in[2*(MAP_W*r+c) +: 2] = cur_map[r][c];
  end

  function automatic logic [1:0] model_px(input int i);
    int r, c;
    logic [1:0] m;
    r = i / POOL_W;
    c = i % POOL_W;
    m = 2'd0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (cur_map[2*r+dr][2*c+dc] > m) m = cur_map[2*r+dr][2*c+dc];
    return m;
  endfunction

  // scoreboard
  logic [1:0]           exp_q[$];
  logic [4:0]           idx_q[$];
  logic [POOL_BITS-1:0] exp_pool = '0;
  logic [1:0]           seen_px [POOL_N];
  bit                   done_pend = 0;
  int                   cap_cyc = 0;
  int                   stall_cnt = 0;
  int                   acc_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_map_ready", map_ready, 1);
      chk("rst_px_valid", px_valid, 0);
      chk("rst_px_data", px_data, 0);
      chk("rst_px_idx", px_idx, 0);
      chk("rst_pool_out", pool_out, 0);
      chk("rst_done", done, 0);
      exp_q.delete();
      idx_q.delete();
      done_pend = 0;
      exp_pool  = '0;
      acc_cnt   = 0;
    end else begin
      chk("pool_out", pool_out, exp_pool);
      if (exp_q.size() > 0) begin
        chk("run_px_valid", px_valid, 1);
        chk("run_map_ready", map_ready, 0);
        chk("run_done", done, 0);
        chk("px_data", px_data, exp_q[0]);
        chk("px_idx", px_idx, idx_q[0]);
        if (!px_ready) stall_cnt++;
        else begin
          seen_px[idx_q[0]] = px_data;
          exp_pool[2*idx_q[0] +: 2] = exp_q[0];
          void'(exp_q.pop_front());
          void'(idx_q.pop_front());
          acc_cnt++;
          if (exp_q.size() == 0) done_pend = 1;
        end
      end else if (done_pend) begin
        chk("done_pulse", done, 1);
        chk("done_px_valid", px_valid, 0);
        chk("done_map_ready", map_ready, 0);
        chk("done_latency", 64'(cyc - cap_cyc), 64'(26 + stall_cnt));
        done_pend = 0;
      end else begin
        chk("idle_map_ready", map_ready, 1);
        chk("idle_px_valid", px_valid, 0);
        chk("idle_done", done, 0);
        if (map_valid) begin
          for (int i = 0; i < POOL_N; i++) begin
            exp_q.push_back(model_px(i));
            idx_q.push_back(5'(i));
          end
          exp_pool  = '0;
          cap_cyc   = cyc;
          stall_cnt = 0;
          acc_cnt   = 0;
        end
      end
    end
  end

  // px_ready driver: 0 = always, 1 = pattern 1,0,0, 2 = random
  int ready_mode = 0;
  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       px_ready = (cyc % 3 == 0);
        2:       px_ready = 1'($urandom_range(0, 1));
        default: px_ready = 1'b1;
      endcase
    end
  end

  // driver tasks
  task automatic wait_capture();
    int n = 0;
    @(negedge clk);
    while (!map_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("capture_wait", map_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_map();
    map_valid = 1'b1;
    wait_capture();
    map_valid = 1'b0;
    wait_done();
  endtask

  task automatic fill_map(input int kind);
    for (int r = 0; r < MAP_W; r++)
      for (int c = 0; c < MAP_W; c++)
        case (kind)
          0:       cur_map[r][c] = 2'd0;
          1:       cur_map[r][c] = (r == 0 && c == 0) ? 2'd3 : ((r == 9 && c == 9) ? 2'd2 : 2'd0);
          2:       cur_map[r][c] = 2'((r + c) % 4);
          default: cur_map[r][c] = 2'($urandom_range(0, 3));
        endcase
  endtask

  initial begin
    rst       = 1'b1;
    map_valid = 1'b0;
    fill_map(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // all-zero map, ready tied high
    fill_map(0);
    run_map();
    chk("zero_pool", pool_out, 0);

    // corner elements only
    fill_map(1);
    run_map();
    chk("corner_pool", pool_out, (50'h2 << 48) | 50'h3);

    // (r+c)%4 map with hand-computed windows
    fill_map(2);
    run_map();
    chk("diag_idx0", seen_px[0], 2);
    chk("diag_idx1", seen_px[1], 3);
    chk("diag_idx6", seen_px[6], 2);

    // stall pattern 1,0,0
    ready_mode = 1;
    fill_map(3);
    run_map();
    ready_mode = 0;

    // map_valid held through RUN with a different map waiting behind
    fill_map(2);
    map_valid = 1'b1;
    wait_capture();
    fill_map(1);
    wait_done();
    wait_capture();
    map_valid = 1'b0;
    wait_done();
    chk("held_second_pool", pool_out, (50'h2 << 48) | 50'h3);

    // reset at pixel 12, then a normal map
    fill_map(3);
    map_valid = 1'b1;
    wait_capture();
    map_valid = 1'b0;
    for (int n = 0; n < 100 && acc_cnt < 12; n++) @(posedge clk);
    chk("reached_px12", acc_cnt, 12);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("no_done_after_rst", done, 0);
    fill_map(3);
    run_map();

    // random maps with random backpressure
    ready_mode = 2;
    for (int m = 0; m < 5; m++) begin
      fill_map(3);
      run_map();
    end
    ready_mode = 0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
